// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Holds the frame FSM state encoding, R/W command encoding and frame-length helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    OVERRUN
  } spi_state_t;

  localparam logic SPI_WRITE = 1'b1;
  localparam logic SPI_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input, with rise/fall pulses.
// Level output lags the raw input by STAGES clks; pulses come from the last two stages.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register file: R/W bit, address, data MSB first; read-back on cipo.
// Writes commit one clk after ncs rising is seen, only for complete in-range write frames.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int                FRAME_LEN  = frame_len(ADDR_W, DATA_W);
  localparam int                CNT_W      = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ncs_rise, ncs_fall, ncs_lvl;
  logic copi_s, copi_rise_unused, copi_fall_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .q    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ncs),
    .q    (ncs_lvl),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (copi),
    .q    (copi_s),
    .rise (copi_rise_unused),
    .fall (copi_fall_unused)
  );

  spi_state_t                  state_q, state_n;
  logic [CNT_W-1:0]            cnt_q;
  logic [ADDR_W-1:0]           asr_q, asr_next, addr_q;
  logic [DATA_W-1:0]           dsr_q, rbuf_q, rd_word;
  logic                        rw_q;
  logic                        commit_q;
  logic [NUM_REGS*DATA_W-1:0]  regs_q;
  logic                        addr_ok;

  logic clr, lat_rw, sh_addr, lat_addr, sh_data, commit, err;

  assign asr_next = (asr_q << 1) | ADDR_W'(copi_s);
  assign addr_ok  = ({1'b0, addr_q} < NUM_REGS_A);
  assign regs_out = regs_q;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (asr_next == k[ADDR_W-1:0]) rd_word = regs_q[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // ncs rising wins over any coincident sclk edge.
  always_comb begin
    state_n  = state_q;
    clr      = 1'b0;
    lat_rw   = 1'b0;
    sh_addr  = 1'b0;
    lat_addr = 1'b0;
    sh_data  = 1'b0;
    commit   = 1'b0;
    err      = 1'b0;
    if (ncs_rise) begin
      state_n = IDLE;
      if (state_q == DATA && cnt_q == FULL_CNT) begin
        commit = (rw_q == SPI_WRITE) && addr_ok;
      end else if (state_q != IDLE) begin
        err = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_n = CMD;
            clr     = 1'b1;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            state_n = ADDR;
            lat_rw  = 1'b1;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            sh_addr = 1'b1;
            if (cnt_q == LAST_ADDR) begin
              lat_addr = 1'b1;
              state_n  = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            if (cnt_q == FULL_CNT) state_n = OVERRUN;
            else                   sh_data = 1'b1;
          end
        end
        OVERRUN: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      asr_q     <= '0;
      dsr_q     <= '0;
      addr_q    <= '0;
      rw_q      <= SPI_READ;
      rbuf_q    <= '0;
      cipo      <= 1'b0;
      cipo_oe   <= 1'b0;
      commit_q  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      regs_q    <= '0;
    end else begin
      cipo_oe   <= ~ncs_lvl;
      commit_q  <= commit;
      wr_strobe <= commit_q;
      frame_err <= err;
      if (clr) begin
        cnt_q <= '0;
        asr_q <= '0;
        dsr_q <= '0;
      end
      if (lat_rw) begin
        rw_q  <= copi_s;
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (sh_addr) begin
        asr_q <= asr_next;
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (lat_addr) begin
        addr_q <= asr_next;
        rbuf_q <= (rw_q == SPI_READ) ? rd_word : '0;
      end
      if (sh_data) begin
        dsr_q <= (dsr_q << 1) | DATA_W'(copi_s);
        cnt_q <= cnt_q + CNT_ONE;
      end
      // Read data leaves MSB first, one bit per sclk falling edge in DATA.
      if (state_q == DATA && !ncs_rise) begin
        if (sclk_fall) begin
          cipo   <= rbuf_q[DATA_W-1];
          rbuf_q <= rbuf_q << 1;
        end
      end else begin
        cipo <= 1'b0;
      end
      if (commit_q) begin
        wr_addr <= addr_q;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (addr_q == k[ADDR_W-1:0]) regs_q[k*DATA_W +: DATA_W] <= dsr_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboarded bench: stimulus queues expected commits, errors and read words;
// monitors pop and compare whenever the DUT strobes, flags an error or finishes a read.
module tb_spi_regfile_peripheral;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs0 = 1'b1;
  logic ncs1 = 1'b1;

  logic         cipo0, cipo_oe0, wr_strobe0, frame_err0;
  logic [39:0]  regs_out0;
  logic [6:0]   wr_addr0;
  logic         cipo1, cipo_oe1, wr_strobe1, frame_err1;
  logic [127:0] regs_out1;
  logic [2:0]   wr_addr1;

  int errors = 0;
  int checks = 0;

  logic [39:0]  model0 = '0;
  logic [127:0] model1 = '0;
  logic [6:0]   exp_wa0[$];
  logic [39:0]  exp_rg0[$];
  logic [39:0]  exp_er0[$];
  logic [7:0]   exp_rd0[$];
  logic [2:0]   exp_wa1[$];
  logic [127:0] exp_rg1[$];
  logic [15:0]  exp_rd1[$];

  always #5 clk = ~clk;

  spi_regfile_peripheral u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs0),
    .cipo(cipo0), .cipo_oe(cipo_oe0), .regs_out(regs_out0),
    .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .frame_err(frame_err0)
  );

  spi_regfile_peripheral #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs1),
    .cipo(cipo1), .cipo_oe(cipo_oe1), .regs_out(regs_out1),
    .wr_strobe(wr_strobe1), .wr_addr(wr_addr1), .frame_err(frame_err1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got a pulse, required none", name);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input int sel, input logic [31:0] bits, input int len);
    if (sel == 0) ncs0 = 1'b0;
    else          ncs1 = 1'b0;
    repeat (8) @(negedge clk);
    shift_bits(bits, len);
    repeat (4) @(negedge clk);
    ncs0 = 1'b1;
    ncs1 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wr0(input logic [6:0] a, input logic [7:0] d);
    model0[a*8 +: 8] = d;
    exp_wa0.push_back(a);
    exp_rg0.push_back(model0);
    frame(0, {16'h0, 1'b1, a, d}, 16);
  endtask

  task automatic rd0(input logic [6:0] a, input logic [7:0] exp);
    exp_rd0.push_back(exp);
    frame(0, {16'h0, 1'b0, a, 8'h00}, 16);
  endtask

  // Commit and frame-error monitor.
  initial begin : pulse_mon
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_strobe0) begin
          if (exp_wa0.size() == 0) unexpected("wr_strobe0");
          else begin
            check("wr_addr0", wr_addr0, exp_wa0.pop_front());
            check("regs_out0_commit", regs_out0, exp_rg0.pop_front());
          end
        end
        if (frame_err0) begin
          if (exp_er0.size() == 0) unexpected("frame_err0");
          else check("regs_out0_err", regs_out0, exp_er0.pop_front());
        end
        if (wr_strobe1) begin
          if (exp_wa1.size() == 0) unexpected("wr_strobe1");
          else begin
            check("wr_addr1", wr_addr1, exp_wa1.pop_front());
            check("regs_out1_commit", regs_out1, exp_rg1.pop_front());
          end
        end
        if (frame_err1) unexpected("frame_err1");
      end
    end
  end

  // Read-back monitor for the default instance: samples cipo on sclk rise in the data phase.
  initial begin : rd_mon0
    int n;
    logic rw;
    logic [7:0] w;
    forever begin
      @(negedge ncs0);
      n = 0; rw = 1'b1; w = '0;
      while (ncs0 == 1'b0) begin
        @(posedge sclk or posedge ncs0);
        if (ncs0 == 1'b0) begin
          check("cipo_oe0_in_frame", cipo_oe0, 1);
          if (n == 0)      rw = copi;
          else if (n >= 8) w = {w[6:0], cipo0};
          n++;
        end
      end
      if (n == 16 && rw == 1'b0) begin
        if (exp_rd0.size() == 0) unexpected("read0");
        else check("read0_data", w, exp_rd0.pop_front());
      end
    end
  end

  initial begin : rd_mon1
    int n;
    logic rw;
    logic [15:0] w;
    forever begin
      @(negedge ncs1);
      n = 0; rw = 1'b1; w = '0;
      while (ncs1 == 1'b0) begin
        @(posedge sclk or posedge ncs1);
        if (ncs1 == 1'b0) begin
          if (n == 0)      rw = copi;
          else if (n >= 4) w = {w[14:0], cipo1};
          n++;
        end
      end
      if (n == 20 && rw == 1'b0) begin
        if (exp_rd1.size() == 0) unexpected("read1");
        else check("read1_data", w, exp_rd1.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (4) @(negedge clk);
    check("rst_regs_out0", regs_out0, 0);
    check("rst_cipo0", cipo0, 0);
    check("rst_cipo_oe0", cipo_oe0, 0);
    check("rst_wr_strobe0", wr_strobe0, 0);
    check("rst_wr_addr0", wr_addr0, 0);
    check("rst_frame_err0", frame_err0, 0);
    check("rst_regs_out1", regs_out1, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    wr0(7'd0, 8'hA5);
    wr0(7'd4, 8'h3C);
    rd0(7'd4, 8'h3C);
    rd0(7'd0, 8'hA5);
    check("cipo_oe0_idle", cipo_oe0, 0);

    // Out-of-range write is silently dropped; reads there return zero.
    frame(0, {16'h0, 1'b1, 7'd5, 8'h55}, 16);
    rd0(7'd5, 8'h00);

    exp_er0.push_back(model0);
    frame(0, 32'h207, 10);
    exp_er0.push_back(model0);
    frame(0, {15'h0, 1'b1, 7'd2, 8'h55, 1'b1}, 17);
    rd0(7'd1, 8'h00);
    rd0(7'd2, 8'h00);

    // Reset in the middle of the data phase of a write.
    wr0(7'd3, 8'hFF);
    ncs0 = 1'b0;
    repeat (8) @(negedge clk);
    shift_bits({20'h0, 1'b1, 7'd3, 4'h0}, 12);
    rst_n = 1'b0;
    ncs0  = 1'b1;
    repeat (2) @(negedge clk);
    model0 = '0;
    check("midrst_regs_out0", regs_out0, 0);
    check("midrst_cipo0", cipo0, 0);
    check("midrst_cipo_oe0", cipo_oe0, 0);
    check("midrst_wr_strobe0", wr_strobe0, 0);
    check("midrst_wr_addr0", wr_addr0, 0);
    check("midrst_frame_err0", frame_err0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    wr0(7'd2, 8'h5A);
    rd0(7'd3, 8'h00);
    rd0(7'd2, 8'h5A);

    // Wide-data instance.
    model1[112 +: 16] = 16'hBEEF;
    exp_wa1.push_back(3'd7);
    exp_rg1.push_back(model1);
    frame(1, {12'h0, 1'b1, 3'd7, 16'hBEEF}, 20);
    model1[0 +: 16] = 16'h1234;
    exp_wa1.push_back(3'd0);
    exp_rg1.push_back(model1);
    frame(1, {12'h0, 1'b1, 3'd0, 16'h1234}, 20);
    exp_rd1.push_back(16'hBEEF);
    frame(1, {12'h0, 1'b0, 3'd7, 16'h0000}, 20);
    exp_rd1.push_back(16'h1234);
    frame(1, {12'h0, 1'b0, 3'd0, 16'h0000}, 20);

    repeat (20) @(negedge clk);
    check("pending_commits0", exp_wa0.size(), 0);
    check("pending_errors0", exp_er0.size(), 0);
    check("pending_reads0", exp_rd0.size(), 0);
    check("pending_commits1", exp_wa1.size(), 0);
    check("pending_reads1", exp_rd1.size(), 0);
    check("final_regs_out0", regs_out0, model0);
    check("final_regs_out1", regs_out1, model1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
